// File: rtl/ps2_pkg.sv
// Shared constants, deframer state encoding and frame check for the PS/2 keyboard receiver.
// The frame check covers the start, stop and odd-parity bits of a device-to-host frame.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // Odd parity means the eight data bits together with the parity bit hold an odd number of ones.
  function automatic logic frame_ok(input logic       start_bit,
                                    input logic [7:0] code,
                                    input logic       parity_bit,
                                    input logic       stop_bit);
    return (!start_bit) && stop_bit && ((^code) ^ parity_bit);
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Host-side handshake between the PS/2 receiver and the scan-code consumer.
// The master modport is the receiver side; the slave modport is the host side.
interface ps2_keyboard_rx_if ();

  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (
    input  nextdata_n,
    output data,
    output ready,
    output overflow,
    output frame_err
  );

  modport slave (
    output nextdata_n,
    input  data,
    input  ready,
    input  overflow,
    input  frame_err
  );

endinterface

// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO with a registered occupancy count; the storage array itself is not reset.
// A push while full is accepted only when a pop frees an entry on the same edge.
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rdata = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames, checks them
// and queues good scan codes for the host behind a ready/consume handshake.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master host
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  rx_state_e              state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          timeout_q, timeout_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  logic       ps2_fall;
  logic       ps2_bit;
  logic       push;
  logic       pop;
  logic [7:0] rdata;
  logic       empty;
  logic       full;

  // Bit 0 of each chain is the newest sample; the top bit is the oldest.
  assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
  assign ps2_fall    = clk_sync_q[SYNC_STAGES-1] && !clk_sync_q[SYNC_STAGES-2];
  assign ps2_bit     = data_sync_q[SYNC_STAGES-1];

  assign pop = !host.nextdata_n && !empty;

  // The shift register holds start, data and parity; the stop bit is checked as it arrives.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    timeout_d   = timeout_q;
    frame_err_d = frame_err_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = 4'd0;
        timeout_d = '0;
        if (ps2_fall) begin
          shift_d   = {ps2_bit, shift_q[9:1]};
          bit_cnt_d = 4'd1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (ps2_fall) begin
          timeout_d = '0;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            if (frame_ok(shift_q[0], shift_q[8:1], shift_q[9], ps2_bit)) begin
              push = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            shift_d   = {ps2_bit, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        timeout_d = '0;
      end
    endcase
    overflow_d = overflow_q || (push && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      timeout_q   <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .wdata (shift_q[8:1]),
    .pop   (!host.nextdata_n),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );

  assign host.ready     = !empty;
  assign host.data      = empty ? 8'h00 : rdata;
  assign host.overflow  = overflow_q;
  assign host.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frame stimulus pushes expected scan codes,
// a forked monitor pops and compares them whenever the host consumes an entry.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int SYNC  = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int HALF  = 6;

  logic clk     = 1'b0;
  logic clrn    = 1'b0;
  logic ps2Clk  = 1'b1;
  logic ps2Data = 1'b1;

  ps2_keyboard_rx_if hostIf ();

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .host     (hostIf)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         latency;
  logic [7:0] expQ[$];
  logic       expOverflow;
  logic       expFrameErr;

  // Scan codes 0x01..0x08 (and 0x09) with hand-computed odd-parity bits.
  logic [7:0] fillCode [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
  logic       fillPar  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expData;
    expData = (expQ.size() > 0) ? expQ[0] : 8'h00;
    check({tag, "_ready"},     32'(hostIf.ready),     32'(expQ.size() > 0));
    check({tag, "_data"},      32'(hostIf.data),      32'(expData));
    check({tag, "_overflow"},  32'(hostIf.overflow),  32'(expOverflow));
    check({tag, "_frame_err"}, 32'(hostIf.frame_err), 32'(expFrameErr));
  endtask

  task automatic monitorLoop();
    logic [7:0] expData;
    forever begin
      @(negedge clk);
      if (clrn && hostIf.ready && !hostIf.nextdata_n) begin
        if (expQ.size() == 0) begin
          check("consume_unexpected", 32'(hostIf.data), 32'hFFFF_FFFF);
        end else begin
          expData = expQ.pop_front();
          check("consume_data", 32'(hostIf.data), 32'(expData));
        end
      end
    end
  endtask

  task automatic doReset();
    clrn = 1'b0;
    @(posedge clk);
    #1 clrn = 1'b1;
    expQ.delete();
    expOverflow = 1'b0;
    expFrameErr = 1'b0;
  endtask

  task automatic driveBit(input logic b);
    ps2Data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2Clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2Clk = 1'b1;
  endtask

  task automatic drain(input int n);
    hostIf.nextdata_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 hostIf.nextdata_n = 1'b1;
  endtask

  // Sends a whole frame; optionally pulses nextdata_n onto the clk edge that commits the stop bit.
  task automatic applyStimulus(input logic [7:0] code, input logic par,
                               input bit popOnCommit, input bit expectGood);
    logic [9:0] frame;
    frame = {par, code, 1'b0};
    for (int b = 0; b < 10; b++) begin
      driveBit(frame[b]);
    end
    ps2Data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2Clk = 1'b0;
    latency = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk);
      #1;
      if (latency < 0 && hostIf.ready) begin
        latency = i;
      end
      hostIf.nextdata_n = !(popOnCommit && (i == SYNC - 1));
    end
    ps2Clk = 1'b1;
    if (expectGood) begin
      if (expQ.size() < DEPTH) begin
        expQ.push_back(code);
      end else begin
        expOverflow = 1'b1;
      end
    end else begin
      expFrameErr = 1'b1;
    end
  endtask

  initial begin
    hostIf.nextdata_n = 1'b1;
    expOverflow = 1'b0;
    expFrameErr = 1'b0;
    fork
      monitorLoop();
    join_none
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    checkOutput("reset");

    $display("[TB] good frame 0x1C then single pop");
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1);
    check("t1_latency_in_bound", 32'(latency >= 1 && latency <= SYNC + 2), 32'd1);
    checkOutput("t1_loaded");
    drain(1);
    checkOutput("t1_popped");
    drain(3);
    checkOutput("t1_pop_empty");

    $display("[TB] bad parity frame 0x1C");
    applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_parity");

    $display("[TB] nine frames without pops");
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(fillCode[k], fillPar[k], 1'b0, 1'b1);
    end
    checkOutput("t3_full");
    drain(8);
    checkOutput("t3_drained");

    $display("[TB] partial frame then timeout");
    doReset();
    driveBit(1'b0);
    for (int b = 0; b < 4; b++) begin
      driveBit(PS2_EXTEND[b]);
    end
    repeat (TMO + 1 + HALF) @(posedge clk);
    #1;
    applyStimulus(8'h2A, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_after_timeout");
    drain(1);
    checkOutput("t4_drained");

    $display("[TB] reset in the middle of a frame");
    driveBit(1'b0);
    for (int b = 0; b < 4; b++) begin
      driveBit(PS2_BREAK[b]);
    end
    doReset();
    applyStimulus(PS2_BREAK, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_after_reset");
    drain(2);
    checkOutput("t5_drained");

    $display("[TB] push while full with pop on the commit edge");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(fillCode[k], fillPar[k], 1'b0, 1'b1);
    end
    checkOutput("t6_full");
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_same_edge");
    check("t6_model_count", 32'(expQ.size()), 32'd8);
    drain(8);
    checkOutput("t6_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver: synchronises the external ps2_clk/ps2_data pair, deframes 11-bit device-to-host frames and checks them.
- Buffers valid scan codes in a small FIFO and presents them through a ready/consume handshake.
- Sits directly upstream of the hex/seven-segment display path; data[3:0] and data[7:4] feed the digit decoders.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; power of 2, minimum 2.
- SYNC_STAGES, 3, flip-flop depth of the ps2_clk/ps2_data synchronisers; minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge after which a partial frame is aborted.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clrn  in  1  synchronous, active-low reset.
- ps2_clk  in  1  asynchronous PS/2 clock pin.
- ps2_data  in  1  asynchronous PS/2 data pin.
- nextdata_n  in  1  active-low consume strobe; pops one entry per cycle while low and ready=1.
- data  out  8  scan code at the FIFO head; 8'h00 while ready=0.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky; a valid frame was dropped because the FIFO was full.
- frame_err  out  1  sticky; a frame failed the start, stop or parity check.

Behaviour:
- Reset (clrn=0 at a clk edge):
  - FIFO pointers, FIFO count, bit counter and timeout counter go to 0.
  - Synchroniser chains load 1 (idle bus).
  - ready=0, data=8'h00, overflow=0, frame_err=0. FIFO storage is not reset.
- Reset mid-frame discards the partial frame completely.
- Sync and edge detect:
  - ps2_clk and ps2_data pass through identical SYNC_STAGES chains.
  - A falling edge is the last two stages of the clk chain reading 1 then 0.
  - The data bit is sampled from the data chain on that same cycle.
- Deframer (bit counter 0..10, states IDLE/RECV):
  - IDLE: counter=0. On a falling edge, shift the bit in, counter=1, go to RECV.
  - RECV: each falling edge shifts a bit in LSB-first and increments the counter.
  - On the edge where counter==10 (stop bit), check:
    - start bit == 0
    - stop bit == 1
    - data[7:0] XOR parity bit == 1 (odd parity)
  - Frame passes: push to FIFO.
  - Frame fails: set frame_err and drop the frame.
  - Either way, the counter returns to 0 and the state returns to IDLE.
  - Timeout: in RECV, the timeout counter increments on each cycle with no falling edge and clears on each edge. On reaching TIMEOUT_CYCLES the frame is aborted (go to IDLE, counter 0). A timeout does not set frame_err.
- FIFO:
  - Push happens at the clk edge on which the stop bit is detected.
  - ready and data are valid from the next cycle.
  - Latency from a ps2_clk pin fall to ready is at most SYNC_STAGES+2 clk cycles.
- Pop:
  - Occurs on a clk edge where nextdata_n=0 and ready=1; the read pointer advances.
  - A pop while empty is ignored.
  - A host holding nextdata_n low drains one entry per cycle.
- Push while full:
  - Accepted if a pop happens on the same edge; count stays at FIFO_DEPTH and overflow is not set.
  - Otherwise the frame is dropped and overflow is set.
- Push and pop on the same edge while not full: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a count register of width log2(FIFO_DEPTH)+1.
- overflow and frame_err clear only on reset.

Decomposition:
- Package ps2_pkg holds:
  - PS2_FRAME_BITS=11
  - PS2_BREAK=8'hF0
  - PS2_EXTEND=8'hE0
  - the deframer state encoding (IDLE, RECV)
- Sub-module ps2_fifo: synchronous FIFO with parameter DEPTH and ports clk, clrn, push, wdata, pop, rdata, empty, full. It carries the same clk/clrn convention.
- The synchronisers, deframer and timeout stay in ps2_keyboard_rx.

Test Plan:
- Send frame 0x1C with parity=0 (bits 0,0,0,1,1,1,0,0,0,0,1 on the wire) -> ready=1, data=8'h1C within SYNC_STAGES+2 cycles of the last ps2_clk fall. Hold nextdata_n low 1 cycle -> ready=0, data=8'h00.
- Send 0x1C with parity=1 -> ready stays 0, frame_err=1, overflow=0.
- Send 0x01..0x09 with no pops -> overflow=1 after the 9th frame. Then pop 8 times -> data reads 01..08 in order, then ready=0.
- Send start bit plus 4 bits of a frame, idle TIMEOUT_CYCLES+1 cycles (bench sets TIMEOUT_CYCLES=100), then send a full 0x2A frame with parity=0 -> data=8'h2A, frame_err=0.
- Send 4 bits of a frame, pulse clrn low 1 cycle, then send 0xF0 with parity=1 -> exactly one entry, 8'hF0; overflow=0, frame_err=0.
- Fill the FIFO with 8 frames, then hold nextdata_n low on the exact cycle the 9th frame (0x55, parity=1) commits -> overflow=0, count stays 8, head advances to the 2nd entry, 0x55 is read last.
